// File: rtl/tetris_pkg.sv
// Shared board geometry and writer FSM state type for the tetris datapath.
package tetris_pkg;

  localparam int unsigned BOARD_W = 10;
  localparam int unsigned BOARD_H = 20;
  localparam int unsigned CELLS   = 200;
  localparam int unsigned PIECE_N = 4;

  typedef enum logic [1:0] {
    StIdle,
    StMerge,
    StScan,
    StDone
  } state_e;

endpackage

// File: rtl/piece_mask.sv
// Maps a 4x4 piece bitmap anchored at its bottom-right cell onto the 10x20 board.
module piece_mask
  import tetris_pkg::*;
(
  input  logic [3:0]                   pos_x,
  input  logic [4:0]                   pos_y,
  input  logic [0:PIECE_N*PIECE_N-1]   float,
  output logic [0:CELLS-1]             mask,
  output logic                         above_top
);

  always_comb begin
    logic signed [5:0] row;
    logic signed [5:0] col;
    row       = '0;
    col       = '0;
    mask      = '0;
    above_top = 1'b0;
    for (int i = 0; i < PIECE_N; i++) begin
      for (int j = 0; j < PIECE_N; j++) begin
        row = 6'(pos_y) + 6'(i) - 6'd3;
        col = 6'(pos_x) + 6'(j) - 6'd3;
        if (float[i*PIECE_N+j]) begin
          // Cells above the board are lost but flag a top-out.
          if (row < 6'sd0) begin
            above_top = 1'b1;
          end else if (col >= 6'sd0 && col <= 6'sd9 && row <= 6'sd19) begin
            mask[8'(row) * 8'd10 + 8'(col)] = 1'b1;
          end
        end
      end
    end
  end

endmodule

// File: rtl/board_writer.sv
// Merges a locked piece into the static field and collapses full rows bottom-up.
// static_field is the settled-board output (named to avoid the reserved word static).
module board_writer
  import tetris_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 lock,
  input  logic                 new_game,
  input  logic [3:0]           pos_x,
  input  logic [4:0]           pos_y,
  input  logic [0:15]          float,
  output logic [0:CELLS-1]     static_field,
  output logic                 busy,
  output logic                 done,
  output logic [2:0]           lines_cleared,
  output logic                 top_out
);

  state_e            state_q;
  logic [4:0]        row_q;
  logic [2:0]        count_q;
  logic [3:0]        pos_x_q;
  logic [4:0]        pos_y_q;
  logic [0:15]       float_q;

  logic [0:CELLS-1]  mask;
  logic              above_top;
  logic [0:CELLS-1]  shifted;
  logic [7:0]        row_base;
  logic              row_full;

  piece_mask u_piece_mask (
    .pos_x     (pos_x_q),
    .pos_y     (pos_y_q),
    .float     (float_q),
    .mask      (mask),
    .above_top (above_top)
  );

  always_comb begin
    row_base = 8'(row_q) * 8'(BOARD_W);
    row_full = &static_field[row_base +: BOARD_W];
  end

  // Rows 0..row_q drop by one; row 0 refills empty; rows below row_q stay put.
  always_comb begin
    shifted = static_field;
    shifted[0 +: BOARD_W] = '0;
    for (int rr = 1; rr < BOARD_H; rr++) begin
      if (rr <= int'(row_q)) begin
        shifted[rr*BOARD_W +: BOARD_W] = static_field[(rr-1)*BOARD_W +: BOARD_W];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= StIdle;
      row_q         <= 5'd19;
      count_q       <= 3'd0;
      pos_x_q       <= '0;
      pos_y_q       <= '0;
      float_q       <= '0;
      static_field  <= '0;
      busy          <= 1'b0;
      done          <= 1'b0;
      lines_cleared <= 3'd0;
      top_out       <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (new_game) begin
            static_field <= '0;
            top_out      <= 1'b0;
          end else if (lock) begin
            pos_x_q <= pos_x;
            pos_y_q <= pos_y;
            float_q <= float;
            busy    <= 1'b1;
            state_q <= StMerge;
          end
        end
        StMerge: begin
          static_field <= static_field | mask;
          if (above_top) top_out <= 1'b1;
          row_q   <= 5'd19;
          count_q <= 3'd0;
          state_q <= StScan;
        end
        StScan: begin
          // A full row is re-checked after the shift since new content lands in it.
          if (row_full) begin
            static_field <= shifted;
            if (count_q < 3'd4) count_q <= count_q + 3'd1;
          end else if (row_q == 5'd0) begin
            done          <= 1'b1;
            lines_cleared <= count_q;
            state_q       <= StDone;
          end else begin
            row_q <= row_q - 5'd1;
          end
        end
        StDone: begin
          busy    <= 1'b0;
          state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_board_writer.sv
// Directed self-checking bench for board_writer.
module tb_board_writer;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         lock;
  logic         new_game;
  logic [3:0]   pos_x;
  logic [4:0]   pos_y;
  logic [0:15]  float_bits;
  logic [0:199] static_field;
  logic         busy;
  logic         done;
  logic [2:0]   lines_cleared;
  logic         top_out;

  int passed = 0;
  int total  = 0;

  logic [0:199] exp_f;
  int           lat;
  logic         b1;

  board_writer dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .lock          (lock),
    .new_game      (new_game),
    .pos_x         (pos_x),
    .pos_y         (pos_y),
    .float         (float_bits),
    .static_field  (static_field),
    .busy          (busy),
    .done          (done),
    .lines_cleared (lines_cleared),
    .top_out       (top_out)
  );

  always #5 clk = ~clk;

  // Pulse lock, return cycles until done (-1 on timeout) and busy after the first edge.
  task automatic do_lock(input logic [3:0] px, input logic [4:0] py, input logic [0:15] fl,
                         output int l, output logic b);
    pos_x = px;
    pos_y = py;
    float_bits = fl;
    lock = 1'b1;
    @(posedge clk); #1;
    lock = 1'b0;
    b = busy;
    l = 1;
    while (done !== 1'b1 && l < 60) begin
      @(posedge clk); #1;
      l++;
    end
    if (done !== 1'b1) l = -1;
    @(posedge clk); #1;
  endtask

  task automatic pulse_new_game();
    new_game = 1'b1;
    @(posedge clk); #1;
    new_game = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; lock = 1'b0; new_game = 1'b0;
    pos_x = '0; pos_y = '0; float_bits = '0;
    repeat (2) @(posedge clk);
    #1;
    total++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy); else passed++;
    total++; if (done !== 1'b0) $display("FAIL reset_done: got %b want 0", done); else passed++;
    total++; if (lines_cleared !== 3'd0) $display("FAIL reset_lines: got %0d want 0", lines_cleared);
    else passed++;
    total++; if (top_out !== 1'b0) $display("FAIL reset_top_out: got %b want 0", top_out); else passed++;
    total++; if (static_field !== '0) $display("FAIL reset_static: got %h want 0", static_field);
    else passed++;
    rst_n = 1'b1;
  endtask

  task automatic test_o_piece();
    exp_f = '0;
    exp_f[188] = 1'b1; exp_f[189] = 1'b1; exp_f[198] = 1'b1; exp_f[199] = 1'b1;
    do_lock(4'd9, 5'd19, 16'h0033, lat, b1);
    total++; if (b1 !== 1'b1) $display("FAIL o_busy_rise: got %b want 1", b1); else passed++;
    total++; if (lat !== 22) $display("FAIL o_latency: got %0d want 22", lat); else passed++;
    total++; if (static_field !== exp_f) $display("FAIL o_static: got %h want %h", static_field, exp_f);
    else passed++;
    total++; if (lines_cleared !== 3'd0) $display("FAIL o_lines: got %0d want 0", lines_cleared);
    else passed++;
  endtask

  task automatic test_four_lines();
    pulse_new_game();
    do_lock(4'd4, 5'd19, 16'hFFFF, lat, b1);
    do_lock(4'd8, 5'd19, 16'hFFFF, lat, b1);
    do_lock(4'd9, 5'd19, 16'h1111, lat, b1);
    exp_f = '0;
    for (int r = 16; r < 20; r++)
      for (int c = 1; c < 10; c++) exp_f[r*10+c] = 1'b1;
    total++; if (static_field !== exp_f)
      $display("FAIL four_preload: got %h want %h", static_field, exp_f);
    else passed++;
    do_lock(4'd3, 5'd19, 16'h8888, lat, b1);
    total++; if (lat !== 26) $display("FAIL four_latency: got %0d want 26", lat); else passed++;
    total++; if (lines_cleared !== 3'd4) $display("FAIL four_lines: got %0d want 4", lines_cleared);
    else passed++;
    total++; if (static_field !== '0) $display("FAIL four_static: got %h want 0", static_field);
    else passed++;
  endtask

  task automatic test_gravity();
    pulse_new_game();
    do_lock(4'd3, 5'd19, 16'h0F0F, lat, b1);
    do_lock(4'd7, 5'd19, 16'h0F0F, lat, b1);
    do_lock(4'd8, 5'd19, 16'h0101, lat, b1);
    do_lock(4'd5, 5'd19, 16'h0010, lat, b1);
    // Completes rows 17 and 19 at column 9.
    do_lock(4'd9, 5'd19, 16'h0101, lat, b1);
    exp_f = '0;
    exp_f[195] = 1'b1;
    total++; if (lat !== 24) $display("FAIL grav_latency: got %0d want 24", lat); else passed++;
    total++; if (lines_cleared !== 3'd2) $display("FAIL grav_lines: got %0d want 2", lines_cleared);
    else passed++;
    total++; if (static_field !== exp_f)
      $display("FAIL grav_static: got %h want %h", static_field, exp_f);
    else passed++;
  endtask

  task automatic test_reset_mid_scan();
    pos_x = 4'd9; pos_y = 5'd1; float_bits = 16'hF033;
    lock = 1'b1;
    @(posedge clk); #1;
    lock = 1'b0;
    repeat (7) @(posedge clk);
    #1;
    total++; if (top_out !== 1'b1) $display("FAIL mid_top_out_set: got %b want 1", top_out); else passed++;
    total++; if (busy !== 1'b1) $display("FAIL mid_busy: got %b want 1", busy); else passed++;
    #2 rst_n = 1'b0;
    #1;
    total++; if (busy !== 1'b0) $display("FAIL rst_busy: got %b want 0", busy); else passed++;
    total++; if (done !== 1'b0) $display("FAIL rst_done: got %b want 0", done); else passed++;
    total++; if (lines_cleared !== 3'd0) $display("FAIL rst_lines: got %0d want 0", lines_cleared);
    else passed++;
    total++; if (top_out !== 1'b0) $display("FAIL rst_top_out: got %b want 0", top_out); else passed++;
    total++; if (static_field !== '0) $display("FAIL rst_static: got %h want 0", static_field);
    else passed++;
    @(posedge clk); #1;
    rst_n = 1'b1;
    do_lock(4'd9, 5'd19, 16'h0033, lat, b1);
    exp_f = '0;
    exp_f[188] = 1'b1; exp_f[189] = 1'b1; exp_f[198] = 1'b1; exp_f[199] = 1'b1;
    total++; if (lat !== 22) $display("FAIL relock_latency: got %0d want 22", lat); else passed++;
    total++; if (static_field !== exp_f)
      $display("FAIL relock_static: got %h want %h", static_field, exp_f);
    else passed++;
  endtask

  task automatic test_top_out();
    pulse_new_game();
    do_lock(4'd5, 5'd1, 16'hF000, lat, b1);
    total++; if (top_out !== 1'b1) $display("FAIL top_set: got %b want 1", top_out); else passed++;
    total++; if (static_field !== '0) $display("FAIL top_static: got %h want 0", static_field);
    else passed++;
    do_lock(4'd9, 5'd19, 16'h0033, lat, b1);
    total++; if (top_out !== 1'b1) $display("FAIL top_sticky: got %b want 1", top_out); else passed++;
    // lock together with new_game: only the clear happens.
    pos_x = 4'd9; pos_y = 5'd19; float_bits = 16'h0033;
    lock = 1'b1; new_game = 1'b1;
    @(posedge clk); #1;
    lock = 1'b0; new_game = 1'b0;
    total++; if (busy !== 1'b0) $display("FAIL both_busy: got %b want 0", busy); else passed++;
    total++; if (static_field !== '0) $display("FAIL both_static: got %h want 0", static_field);
    else passed++;
    total++; if (top_out !== 1'b0) $display("FAIL both_top_out: got %b want 0", top_out); else passed++;
  endtask

  task automatic test_ignore_busy();
    int ndone;
    int lat_first;
    ndone = 0;
    lat_first = -1;
    pos_x = 4'd9; pos_y = 5'd19; float_bits = 16'h0033;
    lock = 1'b1;
    for (int cyc = 1; cyc <= 45; cyc++) begin
      @(posedge clk); #1;
      lock = 1'b0;
      if (cyc == 5) begin
        pos_x = 4'd3; pos_y = 5'd19; float_bits = 16'hF000;
        lock = 1'b1;
      end
      if (done === 1'b1) begin
        ndone++;
        if (lat_first < 0) lat_first = cyc;
      end
    end
    exp_f = '0;
    exp_f[188] = 1'b1; exp_f[189] = 1'b1; exp_f[198] = 1'b1; exp_f[199] = 1'b1;
    total++; if (ndone !== 1) $display("FAIL ign_done_count: got %0d want 1", ndone); else passed++;
    total++; if (lat_first !== 22) $display("FAIL ign_latency: got %0d want 22", lat_first);
    else passed++;
    total++; if (static_field !== exp_f)
      $display("FAIL ign_static: got %h want %h", static_field, exp_f);
    else passed++;
  endtask

  initial begin
    test_reset();
    test_o_piece();
    test_four_lines();
    test_gravity();
    test_reset_mid_scan();
    test_top_out();
    test_ignore_busy();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/board_writer.md
BOARD_WRITER -- requirements
Module: board_writer

Interface
REQ-001 clk  input  1  100MHz system clock; all state on rising edge.
REQ-002 rst_n  input  1  asynchronous, active-low reset.
REQ-003 lock  input  1  one-cycle pulse: merge the falling piece into the static field; honoured only in IDLE.
REQ-004 new_game  input  1  synchronous clear of the static field; honoured only in IDLE; priority over lock.
REQ-005 pos_x  input  4  anchor column, 0-12; anchor is float[15], the bottom-right cell of the 4x4 piece.
REQ-006 pos_y  input  5  anchor row, 0-22.
REQ-007 float  input  [0:15]  piece bitmap, index i*4+j, i = piece row 0-3 (top first), j = piece column 0-3.
REQ-008 static  output  [0:199]  static field, index r*10+c, r = 0-19 (top first), c = 0-9; feeds Combine.
REQ-009 busy  output  1  high in every state except IDLE.
REQ-010 done  output  1  one-cycle pulse when a lock sequence completes.
REQ-011 lines_cleared  output  3  rows removed by the last lock, 0-4; valid from done, held until the next done.
REQ-012 top_out  output  1  sticky flag: a locked cell fell above row 0; drives Display mode.

Function
REQ-013 Cell (i,j) with float bit 1 maps to board row pos_y+i-3 and column pos_x+j-3; compute in 6-bit signed arithmetic.
REQ-014 Mapped cells with a column outside 0-9 or a row above 19 are discarded (upstream guarantees legality).
REQ-015 Mapped cells with a row below 0 are discarded and set top_out.
REQ-016 FSM states: IDLE, MERGE, SCAN, DONE; encoding lives in the package.
REQ-017 IDLE: lock -> MERGE, and busy rises the next cycle; new_game -> static = 0, top_out = 0, stay in IDLE.
REQ-018 MERGE (1 cycle): static <= static OR piece mask; row pointer r <= 19; count <= 0; -> SCAN.
REQ-019 SCAN, row r full (all 10 bits set): rows 0..r-1 move down one row and row 0 clears, all in one cycle; count++; r unchanged, so the same row is re-checked.
REQ-020 SCAN, row r not full: if r == 0 -> DONE, else r--.
REQ-021 DONE (1 cycle): done = 1; lines_cleared <= count; -> IDLE.
REQ-022 Worst-case latency from lock to done is 1 + 20 + 4 + 1 = 26 cycles; a lock with no full rows takes 22 cycles.
REQ-023 lock or new_game while busy is ignored; pulses are not queued.
REQ-024 lock and new_game together in IDLE: new_game only.
REQ-025 A merge over already-set cells is a plain OR; no collision error.
REQ-026 count saturates at 4; lines_cleared never exceeds 4.
REQ-027 static is registered and changes only in MERGE, SCAN-shift, new_game, or reset.

Reset
REQ-028 rst_n low, at any time including mid-SCAN: state = IDLE, static = 0, busy = 0, done = 0, lines_cleared = 0, top_out = 0, r = 19, count = 0.
REQ-029 After release, lock is honoured from the first rising edge with rst_n high.

Structure
REQ-030 Package tetris_pkg holds BOARD_W = 10, BOARD_H = 20, CELLS = 200, PIECE_N = 4 and the FSM state type; Combine and Display share it.
REQ-031 One combinational sub-module, piece_mask, converts (pos_x, pos_y, float) into a 200-bit mask plus an above_top flag; board_writer holds all sequential logic.

Verification
REQ-032 Empty field; O piece (float bits 10, 11, 14, 15 set), pos_x = 9, pos_y = 19, lock -> cells 188, 189, 198, 199 set; done 22 cycles after lock; lines_cleared = 0.
REQ-033 Rows 16-19 preloaded full except column 0; I piece vertical in column 0 (float bits 0, 4, 8, 12), pos_x = 3, pos_y = 19 -> static = 0; lines_cleared = 4; done 26 cycles after lock.
REQ-034 Rows 19 and 17 full, row 18 with only column 5 set; lock a piece elsewhere -> row 18 content ends in row 19, rows 0-18 otherwise empty, lines_cleared = 2.
REQ-035 pos_y = 1 with float row-0 cells set -> top_out = 1 and stays 1 through later locks; new_game in IDLE -> static = 0, top_out = 0.
REQ-036 Second lock 5 cycles after the first -> ignored, only one done; rst_n low mid-SCAN -> all outputs 0 immediately, next lock works normally.
